// File: rtl/imem_fetch_ctrl_if.sv
// Bus bundle for imem_fetch_ctrl: instruction memory, decode queue head,
// redirect from execute, fault flag and the debug read port.
interface imem_fetch_ctrl_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_word;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fault;
  logic        dbg_req;
  logic [31:0] dbg_addr;
  logic        dbg_gnt;
  logic        dbg_rvalid;
  logic [31:0] dbg_rdata;

  modport master (
    output imem_addr,
    input  imem_data,
    output inst_valid,
    input  inst_ready,
    output inst_word,
    output inst_pc,
    input  redirect_valid,
    input  redirect_pc,
    output fault,
    input  dbg_req,
    input  dbg_addr,
    output dbg_gnt,
    output dbg_rvalid,
    output dbg_rdata
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    input  inst_valid,
    output inst_ready,
    input  inst_word,
    input  inst_pc,
    output redirect_valid,
    output redirect_pc,
    input  fault,
    output dbg_req,
    output dbg_addr,
    input  dbg_gnt,
    input  dbg_rvalid,
    input  dbg_rdata
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: PC, 2-entry decode queue, redirects and
// fetch/debug arbitration. Debug read port enabled by IMEM_DBG_PORT_EN.
//
// state    | meaning
// ST_RUN   | fetching sequentially into the queue
// ST_FAULT | stopped on an illegal fetch address, queue still drains
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 51
) (
  input  logic             clk,
  input  logic             rst_n,
  imem_fetch_ctrl_if.master bus
);

  localparam logic [31:0] LAST_ADDR = 32'(4 * MEM_WORDS - 4);

  typedef enum logic {ST_RUN, ST_FAULT} state_t;

  state_t      state_q, state_n;
  logic [31:0] fetch_pc_q, fetch_pc_n;
  logic [31:0] q_pc_q   [2];
  logic [31:0] q_word_q [2];
  logic [31:0] q_pc_n   [2];
  logic [31:0] q_word_n [2];
  logic [1:0]  count_q, count_n;
  logic        pop;
  logic        slot_free;
  logic        fetch_req;
  logic        push;
  logic        dbg_gnt;

  function automatic logic addr_legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a <= LAST_ADDR);
  endfunction

  assign bus.inst_valid = (count_q != 2'd0);
  assign bus.inst_word  = q_word_q[0];
  assign bus.inst_pc    = q_pc_q[0];
  assign bus.fault      = (state_q == ST_FAULT);

  assign pop       = bus.inst_valid && bus.inst_ready;
  assign slot_free = ((count_q - {1'b0, pop}) != 2'd2);
  assign fetch_req = (state_q == ST_RUN) && slot_free && !bus.redirect_valid;

`ifdef IMEM_DBG_PORT_EN
  logic        last_dbg_q;
  logic        dbg_rvalid_q;
  logic [31:0] dbg_rdata_q;

  // On contention the side that did not win last time gets the memory.
  assign dbg_gnt = bus.dbg_req && (!fetch_req || !last_dbg_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_dbg_q   <= 1'b1;
      dbg_rvalid_q <= 1'b0;
      dbg_rdata_q  <= 32'h0;
    end else begin
      dbg_rvalid_q <= dbg_gnt;
      if (dbg_gnt) begin
        dbg_rdata_q <= bus.imem_data;
        last_dbg_q  <= 1'b1;
      end else if (fetch_req) begin
        last_dbg_q  <= 1'b0;
      end
    end
  end

  assign bus.dbg_rvalid = dbg_rvalid_q;
  assign bus.dbg_rdata  = dbg_rdata_q;
`else
  assign dbg_gnt        = 1'b0;
  assign bus.dbg_rvalid = 1'b0;
  assign bus.dbg_rdata  = 32'h0;
`endif

  assign bus.dbg_gnt   = dbg_gnt;
  assign bus.imem_addr = dbg_gnt ? bus.dbg_addr : fetch_pc_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_n;
      fetch_pc_q <= fetch_pc_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    fetch_pc_n = fetch_pc_q;
    push       = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (fetch_req && !dbg_gnt) begin
          if (addr_legal(fetch_pc_q)) begin
            push       = 1'b1;
            fetch_pc_n = fetch_pc_q + 32'd4;
          end else begin
            state_n = ST_FAULT;
          end
        end
      end
      ST_FAULT: state_n = ST_FAULT;
      default:  state_n = ST_RUN;
    endcase
    if (bus.redirect_valid) begin
      fetch_pc_n = bus.redirect_pc;
      state_n    = addr_legal(bus.redirect_pc) ? ST_RUN : ST_FAULT;
    end
  end

  // Empty slots are kept at zero so the head reads 0 when the queue is empty.
  always_comb begin
    q_pc_n   = q_pc_q;
    q_word_n = q_word_q;
    count_n  = count_q;
    if (pop) begin
      q_pc_n[0]   = q_pc_q[1];
      q_word_n[0] = q_word_q[1];
      q_pc_n[1]   = 32'h0;
      q_word_n[1] = 32'h0;
      count_n     = count_q - 2'd1;
    end
    if (push) begin
      if (count_n == 2'd0) begin
        q_pc_n[0]   = fetch_pc_q;
        q_word_n[0] = bus.imem_data;
      end else begin
        q_pc_n[1]   = fetch_pc_q;
        q_word_n[1] = bus.imem_data;
      end
      count_n = count_n + 2'd1;
    end
    if (bus.redirect_valid) begin
      q_pc_n[0]   = 32'h0;
      q_pc_n[1]   = 32'h0;
      q_word_n[0] = 32'h0;
      q_word_n[1] = 32'h0;
      count_n     = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q     <= 2'd0;
      q_pc_q[0]   <= 32'h0;
      q_pc_q[1]   <= 32'h0;
      q_word_q[0] <= 32'h0;
      q_word_q[1] <= 32'h0;
    end else begin
      count_q     <= count_n;
      q_pc_q[0]   <= q_pc_n[0];
      q_pc_q[1]   <= q_pc_n[1];
      q_word_q[0] <= q_word_n[0];
      q_word_q[1] <= q_word_n[1];
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: directed scenarios plus a random
// run against a queue-based reference model.
module tb_imem_fetch_ctrl;
  localparam int          MEM_WORDS = 51;
  localparam logic [31:0] LAST      = 32'(4 * MEM_WORDS - 4);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_fetch_ctrl_if bus ();

  imem_fetch_ctrl #(.RESET_PC(32'h0), .MEM_WORDS(MEM_WORDS)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

`ifdef IMEM_DBG_PORT_EN
  localparam bit DBG_EN = 1'b1;
`else
  localparam bit DBG_EN = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [MEM_WORDS];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    int idx;
    idx = int'(a >> 2);
    if (idx < MEM_WORDS) return mem[idx];
    return 32'hDEAD_BEEF;
  endfunction

  always_comb bus.imem_data = mem_rd(bus.imem_addr);

  // reference model
  typedef struct packed {logic [31:0] pc; logic [31:0] word;} ent_t;
  ent_t        mq[$];
  logic [31:0] m_pc, m_rdata;
  logic        m_fault, m_last_dbg, m_rvalid;
  logic        m_pop, m_want;
  logic        e_valid, e_fault, e_gnt, e_rvalid;
  logic [31:0] e_pc, e_word, e_addr, e_rdata;

  function automatic logic legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a <= LAST);
  endfunction

  function void model_reset();
    mq.delete();
    m_pc = 32'h0; m_fault = 1'b0; m_last_dbg = 1'b1;
    m_rvalid = 1'b0; m_rdata = 32'h0;
  endfunction

  function void model_eval();
    e_valid  = (mq.size() != 0);
    e_pc     = e_valid ? mq[0].pc : 32'h0;
    e_word   = e_valid ? mq[0].word : 32'h0;
    e_fault  = m_fault;
    m_pop    = e_valid && bus.inst_ready;
    m_want   = !m_fault && ((mq.size() - int'(m_pop)) < 2) && !bus.redirect_valid;
    e_gnt    = DBG_EN && bus.dbg_req && (!m_want || !m_last_dbg);
    e_addr   = e_gnt ? bus.dbg_addr : m_pc;
    e_rvalid = m_rvalid;
    e_rdata  = m_rdata;
  endfunction

  function void model_commit();
    if (e_gnt) m_rdata = mem_rd(bus.dbg_addr);
    m_rvalid = e_gnt;
    if (e_gnt) m_last_dbg = 1'b1;
    else if (m_want) m_last_dbg = 1'b0;
    if (bus.redirect_valid) begin
      mq.delete();
      m_pc    = bus.redirect_pc;
      m_fault = !legal(bus.redirect_pc);
    end else begin
      if (m_pop) void'(mq.pop_front());
      if (m_want && !e_gnt) begin
        if (legal(m_pc)) begin
          mq.push_back('{pc: m_pc, word: mem_rd(m_pc)});
          m_pc = m_pc + 32'd4;
        end else begin
          m_fault = 1'b1;
        end
      end
    end
  endfunction

  task automatic settle();
    @(negedge clk);
    model_eval();
  endtask

  task automatic adv();
    model_eval();
    if (!rst_n) model_reset();
    else model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    bus.inst_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.dbg_req = 1'b0;
    bus.dbg_addr = 32'h0;
  endtask

  task automatic do_reset();
    quiet_inputs();
    rst_n = 1'b0;
    repeat (2) adv();
  endtask

  task automatic test_reset();
    do_reset();
    settle();
    checks++; if (bus.inst_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", bus.inst_valid); end
    checks++; if (bus.fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%0h exp=0", bus.fault); end
    checks++; if (bus.dbg_gnt !== 1'b0) begin failures++; $display("FAIL reset_gnt got=%0h exp=0", bus.dbg_gnt); end
    checks++; if (bus.dbg_rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%0h exp=0", bus.dbg_rvalid); end
    checks++; if (bus.dbg_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%0h exp=0", bus.dbg_rdata); end
    checks++; if (bus.imem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%0h exp=0", bus.imem_addr); end
    checks++; if (bus.inst_word !== 32'h0) begin failures++; $display("FAIL reset_word got=%0h exp=0", bus.inst_word); end
    checks++; if (bus.inst_pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%0h exp=0", bus.inst_pc); end
    adv();
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    do_reset();
    bus.inst_ready = 1'b1;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      settle();
      if (k == 0) begin
        checks++; if (bus.inst_valid !== 1'b0) begin failures++; $display("FAIL stream_first_valid got=%0h exp=0", bus.inst_valid); end
        checks++; if (bus.imem_addr !== 32'h0) begin failures++; $display("FAIL stream_first_addr got=%0h exp=0", bus.imem_addr); end
      end else begin
        exp_pc = 32'((k - 1) * 4);
        checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== exp_pc) begin failures++; $display("FAIL stream_pc k=%0d got=%0h/%0h exp=1/%0h", k, bus.inst_valid, bus.inst_pc, exp_pc); end
        checks++; if (bus.inst_word !== mem[k-1]) begin failures++; $display("FAIL stream_word k=%0d got=%0h exp=%0h", k, bus.inst_word, mem[k-1]); end
      end
      adv();
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_pc;
    do_reset();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      settle();
      if (c == 3) begin
        checks++; if (bus.imem_addr !== 32'h8) begin failures++; $display("FAIL stall_addr got=%0h exp=8", bus.imem_addr); end
        checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0) begin failures++; $display("FAIL stall_head got=%0h/%0h exp=1/0", bus.inst_valid, bus.inst_pc); end
      end
      adv();
    end
    bus.inst_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle();
      exp_pc = 32'(k * 4);
      checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== exp_pc || bus.inst_word !== mem[k]) begin
        failures++; $display("FAIL stall_drain k=%0d got=%0h/%0h/%0h exp=1/%0h/%0h", k, bus.inst_valid, bus.inst_pc, bus.inst_word, exp_pc, mem[k]);
      end
      adv();
    end
  endtask

  task automatic test_redirect();
    do_reset();
    rst_n = 1'b1;
    adv();
    adv();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h20;
    settle();
    checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0) begin failures++; $display("FAIL redir_full_head got=%0h/%0h exp=1/0", bus.inst_valid, bus.inst_pc); end
    adv();
    bus.redirect_valid = 1'b0;
    settle();
    checks++; if (bus.inst_valid !== 1'b0) begin failures++; $display("FAIL redir_flush got=%0h exp=0", bus.inst_valid); end
    checks++; if (bus.imem_addr !== 32'h20) begin failures++; $display("FAIL redir_addr got=%0h exp=20", bus.imem_addr); end
    adv();
    settle();
    checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h20 || bus.inst_word !== mem[8]) begin
      failures++; $display("FAIL redir_target got=%0h/%0h/%0h exp=1/20/%0h", bus.inst_valid, bus.inst_pc, bus.inst_word, mem[8]);
    end
    adv();
  endtask

  task automatic test_fault();
    int          n_del;
    logic [31:0] last_pc;
    bit          seen;
    do_reset();
    bus.inst_ready = 1'b1;
    rst_n = 1'b1;
    adv();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h22;
    adv();
    bus.redirect_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      settle();
      checks++; if (bus.fault !== 1'b1 || bus.inst_valid !== 1'b0) begin failures++; $display("FAIL misalign_fault c=%0d got=%0h/%0h exp=1/0", c, bus.fault, bus.inst_valid); end
      adv();
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h10;
    adv();
    bus.redirect_valid = 1'b0;
    settle();
    checks++; if (bus.fault !== 1'b0 || bus.imem_addr !== 32'h10) begin failures++; $display("FAIL fault_clear got=%0h/%0h exp=0/10", bus.fault, bus.imem_addr); end
    adv();
    settle();
    checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h10) begin failures++; $display("FAIL fault_resume got=%0h/%0h exp=1/10", bus.inst_valid, bus.inst_pc); end
    adv();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = LAST - 32'd4;
    adv();
    bus.redirect_valid = 1'b0;
    n_del = 0; last_pc = 32'h0; seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      settle();
      if (bus.fault === 1'b1) seen = 1'b1;
      else if (bus.inst_valid === 1'b1) begin n_del++; last_pc = bus.inst_pc; end
      adv();
    end
    checks++; if (!seen) begin failures++; $display("FAIL overrun_fault got=0 exp=1 within 10 cycles"); end
    checks++; if (n_del != 2 || last_pc !== LAST) begin failures++; $display("FAIL overrun_deliver got=%0d/%0h exp=2/%0h", n_del, last_pc, LAST); end
    for (int c = 0; c < 3; c++) begin
      settle();
      checks++; if (bus.inst_valid !== 1'b0 || bus.fault !== 1'b1) begin failures++; $display("FAIL overrun_nopush c=%0d got=%0h/%0h exp=0/1", c, bus.inst_valid, bus.fault); end
      adv();
    end
  endtask

  task automatic test_debug();
    logic [31:0] exp_pc;
    int          n_del;
    do_reset();
    bus.inst_ready = 1'b1;
    bus.dbg_req = 1'b1;
    bus.dbg_addr = 32'h8;
    rst_n = 1'b1;
    exp_pc = 32'h0;
    n_del = 0;
    for (int c = 0; c < 12; c++) begin
      settle();
      if (DBG_EN) begin
        checks++; if (bus.dbg_gnt !== 1'(c % 2)) begin failures++; $display("FAIL dbg_alt c=%0d got=%0h exp=%0h", c, bus.dbg_gnt, 1'(c % 2)); end
        if (c % 2 == 1) begin
          checks++; if (bus.imem_addr !== 32'h8) begin failures++; $display("FAIL dbg_addr c=%0d got=%0h exp=8", c, bus.imem_addr); end
        end
        checks++; if (bus.dbg_rvalid !== 1'(c >= 2 && c % 2 == 0)) begin failures++; $display("FAIL dbg_rvalid c=%0d got=%0h", c, bus.dbg_rvalid); end
        if (c >= 2 && c % 2 == 0) begin
          checks++; if (bus.dbg_rdata !== mem[2]) begin failures++; $display("FAIL dbg_rdata got=%0h exp=%0h", bus.dbg_rdata, mem[2]); end
        end
      end else begin
        checks++; if (bus.dbg_gnt !== 1'b0 || bus.dbg_rvalid !== 1'b0 || bus.dbg_rdata !== 32'h0) begin
          failures++; $display("FAIL nodbg_tie c=%0d got=%0h/%0h/%0h exp=0/0/0", c, bus.dbg_gnt, bus.dbg_rvalid, bus.dbg_rdata);
        end
        checks++; if (bus.imem_addr !== 32'(c * 4)) begin failures++; $display("FAIL nodbg_addr c=%0d got=%0h exp=%0h", c, bus.imem_addr, 32'(c * 4)); end
      end
      if (bus.inst_valid === 1'b1) begin
        checks++; if (bus.inst_pc !== exp_pc || bus.inst_word !== mem[exp_pc >> 2]) begin
          failures++; $display("FAIL dbg_order got=%0h/%0h exp=%0h/%0h", bus.inst_pc, bus.inst_word, exp_pc, mem[exp_pc >> 2]);
        end
        exp_pc = exp_pc + 32'd4;
        n_del++;
      end
      adv();
    end
    checks++; if (n_del != (DBG_EN ? 6 : 11)) begin failures++; $display("FAIL dbg_throughput got=%0d exp=%0d", n_del, DBG_EN ? 6 : 11); end
  endtask

  task automatic test_random();
    int  r;
    logic prev_gnt;
    do_reset();
    rst_n = 1'b1;
    prev_gnt = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      bus.inst_ready = ($urandom_range(0, 3) != 0);
      bus.redirect_valid = ($urandom_range(0, 24) == 0);
      r = $urandom_range(0, 7);
      if (r == 0) bus.redirect_pc = $urandom;
      else if (r == 1) bus.redirect_pc = 32'($urandom_range(0, MEM_WORDS - 1) * 4 + 2);
      else if (r < 5) bus.redirect_pc = 32'($urandom_range(MEM_WORDS - 6, MEM_WORDS - 1) * 4);
      else bus.redirect_pc = 32'($urandom_range(0, MEM_WORDS - 1) * 4);
      if (!bus.dbg_req || prev_gnt) begin
        bus.dbg_req = ($urandom_range(0, 3) == 0);
        bus.dbg_addr = 32'($urandom_range(0, MEM_WORDS + 3) * 4);
      end
      settle();
      prev_gnt = e_gnt;
      checks++; if (bus.inst_valid !== e_valid) begin failures++; $display("FAIL rnd_valid c=%0d got=%0h exp=%0h", c, bus.inst_valid, e_valid); end
      checks++; if (bus.inst_pc !== e_pc) begin failures++; $display("FAIL rnd_pc c=%0d got=%0h exp=%0h", c, bus.inst_pc, e_pc); end
      checks++; if (bus.inst_word !== e_word) begin failures++; $display("FAIL rnd_word c=%0d got=%0h exp=%0h", c, bus.inst_word, e_word); end
      checks++; if (bus.fault !== e_fault) begin failures++; $display("FAIL rnd_fault c=%0d got=%0h exp=%0h", c, bus.fault, e_fault); end
      checks++; if (bus.dbg_gnt !== e_gnt) begin failures++; $display("FAIL rnd_gnt c=%0d got=%0h exp=%0h", c, bus.dbg_gnt, e_gnt); end
      checks++; if (bus.imem_addr !== e_addr) begin failures++; $display("FAIL rnd_addr c=%0d got=%0h exp=%0h", c, bus.imem_addr, e_addr); end
      checks++; if (bus.dbg_rvalid !== e_rvalid) begin failures++; $display("FAIL rnd_rvalid c=%0d got=%0h exp=%0h", c, bus.dbg_rvalid, e_rvalid); end
      checks++; if (bus.dbg_rdata !== e_rdata) begin failures++; $display("FAIL rnd_rdata c=%0d got=%0h exp=%0h", c, bus.dbg_rdata, e_rdata); end
      adv();
    end
  endtask

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
    quiet_inputs();
    model_reset();
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_fault();
    test_debug();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
